dm_store_buffer: RTL and testbench

- MEM-stage store path, the write-side counterpart of the writeback data selector.
- Accepts store instructions (sb/sh/sw) from the pipeline, aligns the store data to byte lanes and generates byte enables.
- Queues aligned stores in a small FIFO and drains them to data memory over a req/ack handshake, so memory wait states do not stall the pipeline until the queue is full.

---
 rtl/dm_store_buffer.sv | 161 ++++++++++++++++
 tb/tb_dm_store_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_store_buffer.sv
// -----------------------------------------------------------------------------
// dm_store_buffer
//
// MEM-stage store path. It decodes sb/sh/sw, aligns the store data to byte
// lanes and generates byte enables. Aligned stores are queued in a small FIFO
// and drained to data memory over a req/ack handshake, so memory wait states
// only stall the pipeline once the queue is full.
//
// Optional feature: define DM_STORE_FWD_CHECK_EN to add a load/store
// word-address conflict check (ld_check, ld_addr, ld_conflict).
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   st_valid         pipeline presents an instruction this cycle
//   op               opcode: 6'h28 sb, 6'h29 sh, 6'h2b sw, others ignored
//   addr             store byte address
//   rt_data          store data (value held in the low bits)
//   st_ready         a store can be accepted this cycle (count != DEPTH)
//   misalign         one-cycle pulse: a misaligned store was dropped
//   mem_req          head entry valid and presented to memory
//   mem_addr         word-aligned head address (low 2 bits zero)
//   mem_wdata        lane-aligned head write data
//   mem_be           head byte enables, bit i covers bits 8i+7:8i
//   mem_ack          memory accepts the head entry this cycle
//   empty            no buffered stores
//   ld_check         (optional) a load is in MEM this cycle
//   ld_addr          (optional) load byte address
//   ld_conflict      (optional) load hits a buffered store word
// -----------------------------------------------------------------------------
module dm_store_buffer #(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  input  logic [5:0]    op,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   rt_data,
  output logic          st_ready,
  output logic          misalign,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
`ifdef DM_STORE_FWD_CHECK_EN
  input  logic          ld_check,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_conflict,
`endif
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  // Control state
  logic [PW:0]   count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Entry storage holds only the word address; byte offset is encoded in be.
  // Data storage is not reset: outputs are gated by mem_req instead.
  logic [AW-3:0] q_waddr [DEPTH];
  logic [31:0]   q_wdata [DEPTH];
  logic [3:0]    q_be    [DEPTH];

  logic        is_store;
  logic        aligned;
  logic [31:0] fmt_data;
  logic [3:0]  fmt_be;
  logic        enq;
  logic        retire;

  // Decode and lane formatting
  always_comb begin
    is_store = 1'b0;
    aligned  = 1'b0;
    fmt_data = '0;
    fmt_be   = '0;
    case (op)
      6'h28: begin
        is_store = 1'b1;
        aligned  = 1'b1;
        fmt_data = {4{rt_data[7:0]}};
        fmt_be   = 4'b0001 << addr[1:0];
      end
      6'h29: begin
        is_store = 1'b1;
        aligned  = ~addr[0];
        fmt_data = {2{rt_data[15:0]}};
        fmt_be   = addr[1] ? 4'b1100 : 4'b0011;
      end
      6'h2b: begin
        is_store = 1'b1;
        aligned  = (addr[1:0] == 2'b00);
        fmt_data = rt_data;
        fmt_be   = 4'b1111;
      end
      default: ;
    endcase
  end

  assign st_ready = (count != FULL_CNT);
  assign empty    = (count == '0);
  assign mem_req  = ~empty;
  assign enq      = st_valid & is_store & aligned & st_ready;
  assign retire   = mem_req & mem_ack;

  // Head presentation; forced to zero when nothing is queued so stale or
  // uninitialised entries never reach the memory port.
  assign mem_addr  = mem_req ? {q_waddr[rd_ptr], 2'b00} : '0;
  assign mem_wdata = mem_req ? q_wdata[rd_ptr] : '0;
  assign mem_be    = mem_req ? q_be[rd_ptr] : '0;

  // Queue control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      misalign <= 1'b0;
    end else begin
      misalign <= st_valid & is_store & ~aligned & st_ready;
      // Power-of-two depth: pointer overflow is the modulo wrap.
      if (enq)    wr_ptr <= wr_ptr + PW'(1);
      if (retire) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, retire})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue data
  always_ff @(posedge clk) begin
    if (enq) begin
      q_waddr[wr_ptr] <= addr[AW-1:2];
      q_wdata[wr_ptr] <= fmt_data;
      q_be[wr_ptr]    <= fmt_be;
    end
  end

`ifdef DM_STORE_FWD_CHECK_EN
  // An entry is live when its distance from the head is below count; the
  // entry retiring this cycle is still live.
  logic [PW-1:0] offs;
  always_comb begin
    ld_conflict = 1'b0;
    offs        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr;
      if (({1'b0, offs} < count) && (q_waddr[i] == ld_addr[AW-1:2]))
        ld_conflict = ld_check;
    end
  end
`endif

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          st_valid = 1'b0;
  logic [5:0]    op = '0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   rt_data = '0;
  logic          st_ready;
  logic          misalign;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack = 1'b0;
  logic          empty;
`ifdef DM_STORE_FWD_CHECK_EN
  logic          ld_check = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_conflict;
`endif

  dm_store_buffer #(.DEPTH(2), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .op         (op),
    .addr       (addr),
    .rt_data    (rt_data),
    .st_ready   (st_ready),
    .misalign   (misalign),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
`ifdef DM_STORE_FWD_CHECK_EN
    .ld_check   (ld_check),
    .ld_addr    (ld_addr),
    .ld_conflict(ld_conflict),
`endif
    .empty      (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t w;
    w.a = a; w.d = d; w.be = be;
    exp_q.push_back(w);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; op = o; addr = a; rt_data = d;
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (!empty && k < 50) begin step(); k++; end
    if (!empty) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: empty=%b, expected 1", empty);
    end
  endtask

  // Monitor: a write retires at the next edge whenever req and ack are both
  // high; compare it against the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_write: addr %h data %h be %h, expected none",
                 mem_addr, mem_wdata, mem_be);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", mem_addr, w.a);
        chk("wr_data", mem_wdata, w.d);
        chk("wr_be", {28'd0, mem_be}, {28'd0, w.be});
      end
    end
  end

  logic [31:0] hold_a, hold_d;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    rst_n = 1'b1;
    step();

    // Single sw with immediate ack
    mem_ack = 1'b1;
    drive(6'h2b, 32'h100, 32'hDEADBEEF);
    push_exp(32'h100, 32'hDEADBEEF, 4'b1111);
    step();
    st_valid = 1'b0;
    chk("sw_mem_req", {31'd0, mem_req}, 32'd1);
    chk("sw_mem_addr", mem_addr, 32'h100);
    step();
    chk("sw_empty_after", {31'd0, empty}, 32'd1);

    // sb and sh lane formatting, back to back
    drive(6'h28, 32'h203, 32'h123456AB);
    push_exp(32'h200, 32'hABABABAB, 4'b1000);
    step();
    drive(6'h29, 32'h202, 32'h0000CAFE);
    push_exp(32'h200, 32'hCAFECAFE, 4'b1100);
    step();
    drive(6'h29, 32'h200, 32'h00001234);
    push_exp(32'h200, 32'h12341234, 4'b0011);
    step();
    drive(6'h28, 32'h201, 32'h00000055);
    push_exp(32'h200, 32'h55555555, 4'b0010);
    step();
    st_valid = 1'b0;
    wait_empty();

    // Full buffer: third store held, outputs stable
    mem_ack = 1'b0;
    drive(6'h2b, 32'h400, 32'h11111111);
    push_exp(32'h400, 32'h11111111, 4'b1111);
    step();
    drive(6'h2b, 32'h404, 32'h22222222);
    push_exp(32'h404, 32'h22222222, 4'b1111);
    step();
    st_valid = 1'b0;
    chk("full_st_ready", {31'd0, st_ready}, 32'd0);
    chk("full_head_addr", mem_addr, 32'h400);
    hold_a = mem_addr; hold_d = mem_wdata;
    drive(6'h2b, 32'h408, 32'h33333333);
    push_exp(32'h408, 32'h33333333, 4'b1111);
    step();
    chk("held_st_ready", {31'd0, st_ready}, 32'd0);
    chk("held_addr_stable", mem_addr, hold_a);
    chk("held_data_stable", mem_wdata, hold_d);
    step();
    chk("held_data_stable2", mem_wdata, 32'h11111111);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("after_ack_st_ready", {31'd0, st_ready}, 32'd1);
    chk("after_ack_head", mem_addr, 32'h404);
    step();
    st_valid = 1'b0;
    chk("third_accepted_full", {31'd0, st_ready}, 32'd0);
    mem_ack = 1'b1;
    wait_empty();

    // Misaligned stores and a non-store op
    drive(6'h2b, 32'h102, 32'hFFFFFFFF);
    step();
    st_valid = 1'b0;
    chk("mis_sw_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_sw_no_req", {31'd0, mem_req}, 32'd0);
    chk("mis_sw_empty", {31'd0, empty}, 32'd1);
    step();
    chk("mis_pulse_end", {31'd0, misalign}, 32'd0);
    drive(6'h29, 32'h201, 32'h0000BEEF);
    step();
    st_valid = 1'b0;
    chk("mis_sh_pulse", {31'd0, misalign}, 32'd1);
    step();
    chk("mis_sh_pulse_end", {31'd0, misalign}, 32'd0);
    drive(6'h23, 32'h100, 32'h12345678);
    step();
    st_valid = 1'b0;
    chk("nonstore_no_req", {31'd0, mem_req}, 32'd0);
    chk("nonstore_no_mis", {31'd0, misalign}, 32'd0);

    // Streaming: one entry held while enqueue and retire overlap
    mem_ack = 1'b0;
    drive(6'h2b, 32'h500, 32'hA0000000);
    push_exp(32'h500, 32'hA0000000, 4'b1111);
    step();
    mem_ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(6'h2b, 32'h500 + 32'(4 * i), 32'hA0000000 + 32'(i));
      push_exp(32'h500 + 32'(4 * i), 32'hA0000000 + 32'(i), 4'b1111);
      chk("stream_ready", {31'd0, st_ready}, 32'd1);
      step();
      chk("stream_not_empty", {31'd0, empty}, 32'd0);
    end
    st_valid = 1'b0;
    wait_empty();

`ifdef DM_STORE_FWD_CHECK_EN
    mem_ack = 1'b0;
    drive(6'h2b, 32'h300, 32'h0BADF00D);
    push_exp(32'h300, 32'h0BADF00D, 4'b1111);
    step();
    st_valid = 1'b0;
    ld_check = 1'b1; ld_addr = 32'h302;
    #1;
    chk("ld_conflict_hit", {31'd0, ld_conflict}, 32'd1);
    ld_addr = 32'h304;
    #1;
    chk("ld_conflict_miss", {31'd0, ld_conflict}, 32'd0);
    ld_check = 1'b0; ld_addr = 32'h300;
    #1;
    chk("ld_conflict_nocheck", {31'd0, ld_conflict}, 32'd0);
    mem_ack = 1'b1;
    wait_empty();
`endif

    // Reset mid-drain with two entries queued
    mem_ack = 1'b0;
    drive(6'h2b, 32'h600, 32'h66666666);
    step();
    drive(6'h2b, 32'h604, 32'h77777777);
    step();
    st_valid = 1'b0;
    chk("pre_rst_full", {31'd0, st_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    mem_ack = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("postrst_empty", {31'd0, empty}, 32'd1);
    chk("postrst_st_ready", {31'd0, st_ready}, 32'd1);
    mem_ack = 1'b0;

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
